// File: rtl/audio_codec_target.sv
// Codec-side end of the left-justified serial audio link: follows external bclk/lrck, rx word 1 cycle after closing lrck edge,
// adcdat MSB 1 cycle after opening edge; no backpressure, so un-refilled holding registers are resent and flagged as underrun.
module audio_codec_target #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bclk,
  input  logic             lrck,
  input  logic             dacdat,
  output logic             adcdat,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_chan,
  output logic             rx_valid,
  output logic             rx_short,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_chan,
  input  logic             tx_we,
  output logic             tx_req,
  output logic             tx_req_chan,
  output logic             tx_underrun
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             b, l, d;
  logic             b_q, l_q, prime;
  logic             rise, fall, frame;
  logic [WIDTH-1:0] rx_sr, tx_sr;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] hold [2];
  logic [1:0]       written;

  // Sync flops carry no reset so that releasing reset cannot fabricate an edge.
  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [2:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        sync_q[0] <= {bclk, lrck, dacdat};
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
      assign {b, l, d} = sync_q[SYNC_STAGES-1];
    end else begin : g_direct
      assign {b, l, d} = {bclk, lrck, dacdat};
    end
  endgenerate

  assign rise   = prime &  b & ~b_q;
  assign fall   = prime & ~b &  b_q;
  assign frame  = prime & (l ^ l_q);
  assign adcdat = tx_sr[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      prime       <= 1'b0;
      b_q         <= 1'b0;
      l_q         <= 1'b0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      bitcnt      <= '0;
      rx_data     <= '0;
      rx_chan     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_short    <= 1'b0;
      tx_req      <= 1'b0;
      tx_req_chan <= 1'b0;
      tx_underrun <= 1'b0;
      hold[0]     <= '0;
      hold[1]     <= '0;
      written     <= '0;
    end else begin
      prime       <= 1'b1;
      b_q         <= b;
      l_q         <= l;
      rx_valid    <= 1'b0;
      rx_short    <= 1'b0;
      tx_req      <= 1'b0;
      tx_underrun <= 1'b0;

      if (frame) begin
        if (bitcnt == CW'(WIDTH)) begin
          rx_data  <= rx_sr;
          rx_chan  <= l_q;
          rx_valid <= 1'b1;
        end else if (bitcnt != '0) begin
          rx_short <= 1'b1;
        end
        // A rise coinciding with the lrck edge belongs to the new frame.
        if (rise) begin
          rx_sr  <= {{(WIDTH-1){1'b0}}, d};
          bitcnt <= CW'(1);
        end else begin
          bitcnt <= '0;
        end
        tx_sr       <= hold[l];
        tx_req      <= 1'b1;
        tx_req_chan <= l;
        tx_underrun <= ~written[l];
        written[l]  <= 1'b0;
      end else begin
        if (rise && bitcnt < CW'(WIDTH)) begin
          rx_sr  <= {rx_sr[WIDTH-2:0], d};
          bitcnt <= bitcnt + CW'(1);
        end
        if (fall) tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
      end

      // Placed after the load so a colliding write counts toward the next frame.
      if (tx_we) begin
        hold[tx_chan]    <= tx_data;
        written[tx_chan] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_codec_target.sv
// Directed bench acting as the clock master for audio_codec_target.
module tb_audio_codec_target;

  logic        clk = 1'b0;
  logic        reset, bclk, lrck, dacdat, adcdat;
  logic [15:0] rx_data, tx_data;
  logic        rx_chan, rx_valid, rx_short, tx_chan, tx_we;
  logic        tx_req, tx_req_chan, tx_underrun;

  int errors = 0, checks = 0;
  int rxv_cnt = 0, rxs_cnt = 0, txr_cnt = 0;
  logic last_req_chan = 1'b0, last_unr = 1'b0;
  logic [15:0] cap;

  always #5 clk = ~clk;

  audio_codec_target #(.WIDTH(16), .SYNC_STAGES(0)) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .lrck(lrck), .dacdat(dacdat), .adcdat(adcdat),
    .rx_data(rx_data), .rx_chan(rx_chan), .rx_valid(rx_valid), .rx_short(rx_short),
    .tx_data(tx_data), .tx_chan(tx_chan), .tx_we(tx_we),
    .tx_req(tx_req), .tx_req_chan(tx_req_chan), .tx_underrun(tx_underrun)
  );

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (rx_short) rxs_cnt++;
    if (tx_req) begin
      txr_cnt++;
      last_req_chan = tx_req_chan;
      last_unr      = tx_underrun;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One lrck frame of nbits bclk periods; captures adcdat just before each rise.
  task automatic send_frame(input logic lr, input int nbits, input logic [15:0] w,
                            input bit rise_edge, input bit coll, output logic [15:0] c);
    c = '0;
    for (int i = 0; i < nbits; i++) begin
      dacdat = (i < 16) ? w[15-i] : 1'b1;
      if (i == 0 && rise_edge) begin
        bclk = 1'b0;
        step(2);
        lrck = lr;
        bclk = 1'b1;
        step(2);
      end else begin
        if (i == 0) begin
          lrck = lr;
          if (coll) begin
            tx_we   = 1'b1;
            tx_chan = lr;
            tx_data = 16'h0F0F;
          end
        end
        bclk = 1'b0;
        step(1);
        tx_we = 1'b0;
        step(1);
        c = {c[14:0], adcdat};
        bclk = 1'b1;
        step(2);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bclk = 1'b0; lrck = 1'b0; dacdat = 1'b0;
    tx_we = 1'b0; tx_chan = 1'b0; tx_data = '0;
    step(3);
    checks++;
    if ({adcdat, rx_data, rx_chan, rx_valid, rx_short, tx_req, tx_req_chan, tx_underrun} !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {adcdat, rx_data, rx_chan, rx_valid, rx_short, tx_req, tx_req_chan, tx_underrun});
    end
    reset = 1'b0;
    step(3);
    checks++;
    if (rxv_cnt + rxs_cnt + txr_cnt !== 0) begin
      errors++; $display("FAIL reset_no_pulses: got %0d want 0", rxv_cnt + rxs_cnt + txr_cnt);
    end
  endtask

  task automatic test_loopback;
    int v0;
    tx_we = 1'b1; tx_chan = 1'b1; tx_data = 16'hA55A; step(1);
    tx_chan = 1'b0; tx_data = 16'h1234; step(1);
    tx_we = 1'b0; step(1);
    send_frame(1'b1, 16, 16'hBEEF, 0, 0, cap);
    checks++; if (cap !== 16'hA55A) begin errors++; $display("FAIL lb_tx_left: got %h want a55a", cap); end
    checks++; if (txr_cnt !== 1) begin errors++; $display("FAIL lb_req_count: got %0d want 1", txr_cnt); end
    checks++; if (last_req_chan !== 1'b1 || last_unr !== 1'b0) begin
      errors++; $display("FAIL lb_req_left: got chan=%b unr=%b want 1 0", last_req_chan, last_unr); end
    checks++; if (rxv_cnt !== 0 || rxs_cnt !== 0) begin
      errors++; $display("FAIL lb_first_edge: got valid=%0d short=%0d want 0 0", rxv_cnt, rxs_cnt); end
    v0 = rxv_cnt;
    send_frame(1'b0, 16, 16'h5A3C, 0, 0, cap);
    checks++; if (rxv_cnt - v0 !== 1) begin errors++; $display("FAIL lb_rx_valid: got %0d want 1", rxv_cnt - v0); end
    checks++; if (rx_data !== 16'hBEEF || rx_chan !== 1'b1) begin
      errors++; $display("FAIL lb_rx_left: got %h/%b want beef/1", rx_data, rx_chan); end
    checks++; if (cap !== 16'h1234) begin errors++; $display("FAIL lb_tx_right: got %h want 1234", cap); end
    checks++; if (last_req_chan !== 1'b0 || last_unr !== 1'b0) begin
      errors++; $display("FAIL lb_req_right: got chan=%b unr=%b want 0 0", last_req_chan, last_unr); end
  endtask

  task automatic test_underrun;
    send_frame(1'b1, 16, 16'hC3A5, 0, 0, cap);
    checks++; if (rx_data !== 16'h5A3C || rx_chan !== 1'b0) begin
      errors++; $display("FAIL ur_rx_right: got %h/%b want 5a3c/0", rx_data, rx_chan); end
    checks++; if (cap !== 16'hA55A) begin errors++; $display("FAIL ur_resend: got %h want a55a", cap); end
    checks++; if (last_req_chan !== 1'b1 || last_unr !== 1'b1) begin
      errors++; $display("FAIL ur_flag: got chan=%b unr=%b want 1 1", last_req_chan, last_unr); end
  endtask

  task automatic test_frame_priority;
    int v0, s0;
    v0 = rxv_cnt; s0 = rxs_cnt;
    send_frame(1'b0, 16, 16'h9876, 1, 0, cap);
    checks++; if (rxv_cnt - v0 !== 1 || rxs_cnt - s0 !== 0) begin
      errors++; $display("FAIL prio_pulses: got valid=%0d short=%0d want 1 0", rxv_cnt - v0, rxs_cnt - s0); end
    checks++; if (rx_data !== 16'hC3A5 || rx_chan !== 1'b1) begin
      errors++; $display("FAIL prio_prev_word: got %h/%b want c3a5/1", rx_data, rx_chan); end
    send_frame(1'b1, 16, 16'h1111, 0, 0, cap);
    checks++; if (rx_data !== 16'h9876 || rx_chan !== 1'b0) begin
      errors++; $display("FAIL prio_new_word: got %h/%b want 9876/0", rx_data, rx_chan); end
  endtask

  task automatic test_short_long;
    int v0, s0;
    send_frame(1'b0, 10, 16'hFFFF, 0, 0, cap);
    checks++; if (rx_data !== 16'h1111 || rx_chan !== 1'b1) begin
      errors++; $display("FAIL sl_before: got %h/%b want 1111/1", rx_data, rx_chan); end
    v0 = rxv_cnt; s0 = rxs_cnt;
    send_frame(1'b1, 32, 16'hABCD, 0, 0, cap);
    checks++; if (rxs_cnt - s0 !== 1 || rxv_cnt - v0 !== 0) begin
      errors++; $display("FAIL short_pulse: got short=%0d valid=%0d want 1 0", rxs_cnt - s0, rxv_cnt - v0); end
    checks++; if (rx_data !== 16'h1111) begin errors++; $display("FAIL short_data_kept: got %h want 1111", rx_data); end
    v0 = rxv_cnt;
    send_frame(1'b0, 16, 16'h2468, 0, 0, cap);
    checks++; if (rxv_cnt - v0 !== 1 || rx_data !== 16'hABCD || rx_chan !== 1'b1) begin
      errors++; $display("FAIL long_first16: got %0d %h/%b want 1 abcd/1", rxv_cnt - v0, rx_data, rx_chan); end
  endtask

  task automatic test_collision;
    send_frame(1'b1, 16, 16'h1357, 0, 1, cap);
    checks++; if (cap !== 16'hA55A) begin errors++; $display("FAIL coll_old_word: got %h want a55a", cap); end
    checks++; if (last_req_chan !== 1'b1 || last_unr !== 1'b1) begin
      errors++; $display("FAIL coll_req: got chan=%b unr=%b want 1 1", last_req_chan, last_unr); end
    checks++; if (rx_data !== 16'h2468 || rx_chan !== 1'b0) begin
      errors++; $display("FAIL coll_rx: got %h/%b want 2468/0", rx_data, rx_chan); end
    send_frame(1'b0, 16, 16'h0000, 0, 0, cap);
    checks++; if (rx_data !== 16'h1357) begin errors++; $display("FAIL coll_rx2: got %h want 1357", rx_data); end
    send_frame(1'b1, 16, 16'hFACE, 0, 0, cap);
    checks++; if (cap !== 16'h0F0F) begin errors++; $display("FAIL coll_new_word: got %h want 0f0f", cap); end
    checks++; if (last_unr !== 1'b0) begin errors++; $display("FAIL coll_no_underrun: got %b want 0", last_unr); end
  endtask

  task automatic test_reset_mid;
    int v0, s0;
    send_frame(1'b0, 16, 16'h0000, 0, 0, cap);
    checks++; if (rx_data !== 16'hFACE || rx_chan !== 1'b1) begin
      errors++; $display("FAIL rm_before: got %h/%b want face/1", rx_data, rx_chan); end
    send_frame(1'b1, 7, 16'h7F00, 0, 0, cap);
    reset = 1'b1;
    step(2);
    checks++;
    if ({adcdat, rx_data, rx_chan, rx_valid, rx_short, tx_req, tx_req_chan, tx_underrun} !== 23'h0) begin
      errors++;
      $display("FAIL rm_outputs: got %h want 0", {adcdat, rx_data, rx_chan, rx_valid, rx_short, tx_req, tx_req_chan, tx_underrun});
    end
    reset = 1'b0;
    step(3);
    v0 = rxv_cnt; s0 = rxs_cnt;
    send_frame(1'b0, 16, 16'h7E81, 0, 0, cap);
    checks++; if (rxv_cnt - v0 !== 0 || rxs_cnt - s0 !== 0) begin
      errors++; $display("FAIL rm_no_pulse: got valid=%0d short=%0d want 0 0", rxv_cnt - v0, rxs_cnt - s0); end
    checks++; if (cap !== 16'h0000 || last_unr !== 1'b1) begin
      errors++; $display("FAIL rm_tx_cleared: got %h unr=%b want 0000 1", cap, last_unr); end
    v0 = rxv_cnt;
    send_frame(1'b1, 16, 16'h0000, 0, 0, cap);
    checks++; if (rxv_cnt - v0 !== 1 || rx_data !== 16'h7E81 || rx_chan !== 1'b0) begin
      errors++; $display("FAIL rm_recover: got %0d %h/%b want 1 7e81/0", rxv_cnt - v0, rx_data, rx_chan); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_underrun();
    test_frame_priority();
    test_short_long();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
